// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that shares one single-port 1024x32 data memory between a CPU port (0)
// and a DMA/debug port (1). Sub-word stores use read-modify-write; sub-word loads zero-extend.
module dmem_arbiter #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [1:0]        size0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [31:0]       wdata0,
    output logic              ack0,
    output logic              err0,
    output logic [31:0]       rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [1:0]        size1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata1,
    output logic              ack1,
    output logic              err1,
    output logic [31:0]       rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_owner;
    logic              r_we;
    logic              r_err;
    logic              r_rr_last;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_word;
    logic [31:0]       r_rdata0;
    logic [31:0]       r_rdata1;

    logic              w_pick;
    logic              w_sel_we;
    logic [1:0]        w_sel_size;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [31:0]       w_sel_wdata;
    logic              w_bad;
    logic [31:0]       w_merge;
    logic [31:0]       w_load;

    // On a tie the port that did not win last time gets the grant.
    assign w_pick      = (req0 && req1) ? ~r_rr_last : req1;
    assign w_sel_we    = w_pick ? we1    : we0;
    assign w_sel_size  = w_pick ? size1  : size0;
    assign w_sel_addr  = w_pick ? addr1  : addr0;
    assign w_sel_wdata = w_pick ? wdata1 : wdata0;
    assign w_bad       = (w_sel_size == 2'b11)
                      || (w_sel_size == 2'b01 && w_sel_addr[0])
                      || (w_sel_size == 2'b10 && w_sel_addr[1:0] != 2'b00);

    // NOTE: every combinational output gets a default first so no latch can be inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req0 || req1) begin
                    if (w_bad)
                        w_next = DONE;
                    else if (!w_sel_we || w_sel_size != 2'b10)
                        w_next = RD;
                    else
                        w_next = WR;
                end
            end
            RD:      w_next = r_we ? WR : DONE;
            WR:      w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_merge = r_word;
        case (r_size)
            2'b00:   w_merge[{r_addr[1:0], 3'b000} +: 8]  = r_wdata[7:0];
            2'b01:   w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
            default: w_merge = r_wdata;
        endcase
    end

    always_comb begin
        w_load = mem_rdata;
        case (r_size)
            2'b00:   w_load = {24'h0, mem_rdata[{r_addr[1:0], 3'b000} +: 8]};
            2'b01:   w_load = {16'h0, mem_rdata[{r_addr[1], 4'b0000} +: 16]};
            default: w_load = mem_rdata;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_owner   <= 1'b0;
            r_we      <= 1'b0;
            r_err     <= 1'b0;
            r_rr_last <= 1'b1;
            r_size    <= 2'b00;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_word    <= '0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (req0 || req1) begin
                        r_owner <= w_pick;
                        r_we    <= w_sel_we;
                        r_size  <= w_sel_size;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_err   <= w_bad;
                    end
                end
                RD: begin
                    r_word <= mem_rdata;
                    // Load result lands in the owner's register as DONE begins, so it is valid with ack.
                    if (!r_we) begin
                        if (r_owner)
                            r_rdata1 <= w_load;
                        else
                            r_rdata0 <= w_load;
                    end
                end
                DONE:    r_rr_last <= r_owner;
                default: ;
            endcase
        end
    end

    // Write enable decodes straight from state, so an asynchronous reset drops it immediately.
    assign mem_we    = (r_state == WR);
    assign mem_addr  = r_addr;
    assign mem_wdata = (r_state == WR) ? w_merge : 32'h0;
    assign ack0      = (r_state == DONE) && !r_owner;
    assign ack1      = (r_state == DONE) &&  r_owner;
    assign err0      = ack0 && r_err;
    assign err1      = ack1 && r_err;
    assign rdata0    = r_rdata0;
    assign rdata1    = r_rdata1;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed cases plus two randomized requesters,
// scored against a transaction-level memory model applied in acknowledge order.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, we0, req1, we1;
    logic [1:0]  size0, size1;
    logic [11:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        ack0, err0, ack1, err1;
    logic [31:0] rdata0, rdata1;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // Memory environment: untouched words read a fixed pattern.
    logic [31:0] mem     [1024];
    bit          wr_flag [1024];
    int          we_cnt = 0;

    // Reference model state.
    logic [31:0] ref_mem [1024];
    logic [31:0] ref_rdata [2];
    int          exp_writes = 0;

    dmem_arbiter #(.ADDR_W(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .size0(size0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0), .err0(err0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .size1(size1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .err1(err1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int unsigned i);
        return (i * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    function automatic logic [31:0] env_word(input int unsigned i);
        return wr_flag[i] ? mem[i] : init_val(i);
    endfunction

    assign mem_rdata = env_word(32'(mem_addr[11:2]));

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[11:2]]     <= mem_wdata;
            wr_flag[mem_addr[11:2]] <= 1'b1;
            we_cnt                  <= we_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_bad(input logic [1:0] sz, input logic [11:0] ad);
        return (sz == 2'b11) || (sz == 2'b01 && ad[0]) || (sz == 2'b10 && ad[1:0] != 2'b00);
    endfunction

    // Applies one completed transaction to the model memory / per-port load result.
    task automatic model_apply(input int p, input logic we, input logic [1:0] sz,
                               input logic [11:0] ad, input logic [31:0] wd, output logic e_err);
        int unsigned idx, sh;
        logic [31:0] mask, w;
        idx   = ad / 4;
        sh    = (ad % 4) * 8;
        mask  = (sz == 2'b00) ? 32'hFF : (sz == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
        e_err = is_bad(sz, ad);
        if (e_err) return;
        w = ref_mem[idx];
        if (we) begin
            ref_mem[idx] = (w & ~(mask << sh)) | ((wd & mask) << sh);
            exp_writes++;
        end else begin
            ref_rdata[p] = (w >> sh) & mask;
        end
    endtask

    task automatic drive(input int p, input logic rq, input logic we, input logic [1:0] sz,
                         input logic [11:0] ad, input logic [31:0] wd);
        if (p == 0) begin
            req0 = rq; we0 = we; size0 = sz; addr0 = ad; wdata0 = wd;
        end else begin
            req1 = rq; we1 = we; size1 = sz; addr1 = ad; wdata1 = wd;
        end
    endtask

    // Issues one request at a negedge, waits (bounded) for ack, scores it, returns in IDLE.
    task automatic run_txn(input int p, input logic we, input logic [1:0] sz,
                           input logic [11:0] ad, input logic [31:0] wd, input bit exact);
        int   c, w0, exp_lat;
        bit   got;
        logic e_err;
        w0  = we_cnt;
        got = 1'b0;
        exp_lat = is_bad(sz, ad) ? 1 : (we && sz != 2'b10) ? 3 : 2;
        drive(p, 1'b1, we, sz, ad, wd);
        for (c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if ((p == 0) ? ack0 : ack1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check($sformatf("ack timeout p%0d", p), 32'(got), 32'd1);
            drive(p, 1'b0, 1'b0, 2'b00, 12'h0, 32'h0);
            return;
        end
        model_apply(p, we, sz, ad, wd, e_err);
        check($sformatf("err p%0d", p), 32'((p == 0) ? err0 : err1), 32'(e_err));
        check($sformatf("rdata p%0d", p), (p == 0) ? rdata0 : rdata1, ref_rdata[p]);
        if (exact) begin
            check($sformatf("latency p%0d", p), 32'(c), 32'(exp_lat));
            check($sformatf("mem_we pulses p%0d", p), 32'(we_cnt - w0),
                  32'((!e_err && we) ? 1 : 0));
        end
        drive(p, 1'b0, 1'b0, 2'b00, 12'h0, 32'h0);
        @(negedge clk);
    endtask

    task automatic rand_port(input int p, input int n);
        logic [1:0] sz;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            run_txn(p, 1'($urandom_range(0, 1)), sz, 12'($urandom_range(0, 63)), $urandom, 1'b0);
        end
    endtask

    initial begin
        int n, wr0, mism;
        int p;
        logic e_err;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(32'(i));
        ref_rdata[0] = 32'h0;
        ref_rdata[1] = 32'h0;
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 2'b00, 12'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 2'b00, 12'h0, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("reset busy", 32'(busy), 32'd0);
        check("reset ack/err", 32'({ack0, ack1, err0, err1}), 32'd0);
        check("reset rdata0", rdata0, 32'h0);
        check("reset rdata1", rdata1, 32'h0);
        check("reset mem_we", 32'(mem_we), 32'd0);
        check("reset mem_addr", 32'(mem_addr), 32'd0);
        check("reset mem_wdata", mem_wdata, 32'h0);

        // Both ports held high: grants must alternate starting with port 0.
        drive(0, 1'b1, 1'b0, 2'b10, 12'h004, 32'h0);
        drive(1, 1'b1, 1'b0, 2'b10, 12'h008, 32'h0);
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack0 || ack1) begin
                p = ack1 ? 1 : 0;
                check($sformatf("grant order %0d", n), 32'(p), 32'(n % 2));
                model_apply(p, 1'b0, 2'b10, (p == 0) ? 12'h004 : 12'h008, 32'h0, e_err);
                check($sformatf("rr rdata %0d", n), (p == 0) ? rdata0 : rdata1, ref_rdata[p]);
                n++;
            end
        end
        check("rr grants seen", 32'(n), 32'd4);
        drive(0, 1'b0, 1'b0, 2'b00, 12'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 2'b00, 12'h0, 32'h0);
        @(negedge clk);

        run_txn(0, 1'b1, 2'b10, 12'h010, 32'hDEAD_BEEF, 1'b1);
        run_txn(1, 1'b0, 2'b10, 12'h010, 32'h0, 1'b1);
        check("word roundtrip", rdata1, 32'hDEAD_BEEF);

        run_txn(1, 1'b1, 2'b10, 12'h010, 32'h1122_3344, 1'b1);
        run_txn(0, 1'b1, 2'b00, 12'h013, 32'h0000_00AA, 1'b1);
        check("byte rmw word", env_word(4), 32'hAA22_3344);
        run_txn(0, 1'b0, 2'b00, 12'h013, 32'h0, 1'b1);
        check("byte load", rdata0, 32'h0000_00AA);

        run_txn(1, 1'b0, 2'b01, 12'h012, 32'h0, 1'b1);
        check("half load", rdata1, 32'h0000_AA22);
        run_txn(0, 1'b1, 2'b01, 12'h011, 32'h0000_5555, 1'b1);
        check("misaligned unchanged", env_word(4), 32'hAA22_3344);

        run_txn(1, 1'b0, 2'b11, 12'h014, 32'h0, 1'b1);
        check("illegal keeps rdata1", rdata1, 32'h0000_AA22);
        run_txn(0, 1'b0, 2'b10, 12'h010, 32'h0, 1'b1);

        // Two independent randomized requesters.
        wr0 = we_cnt;
        exp_writes = 0;
        fork
            rand_port(0, 30);
            rand_port(1, 30);
        join
        repeat (2) @(negedge clk);
        check("random write count", 32'(we_cnt - wr0), 32'(exp_writes));
        mism = 0;
        for (int i = 0; i < 16; i++) if (env_word(32'(i)) !== ref_mem[i]) mism++;
        check("random memory image", 32'(mism), 32'd0);

        // Reset asserted in the middle of a word store.
        drive(0, 1'b1, 1'b1, 2'b10, 12'h020, 32'h0BAD_F00D);
        @(posedge clk);
        @(negedge clk);
        check("mem_we in WR", 32'(mem_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("reset drops mem_we", 32'(mem_we), 32'd0);
        check("reset drops ack", 32'({ack0, ack1}), 32'd0);
        check("reset busy low", 32'(busy), 32'd0);
        drive(0, 1'b0, 1'b0, 2'b00, 12'h0, 32'h0);
        ref_rdata[0] = 32'h0;
        ref_rdata[1] = 32'h0;
        @(negedge clk);
        check("no write on reset", env_word(8), ref_mem[8]);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset idle", 32'(busy), 32'd0);
        check("post-reset rdata0", rdata0, ref_rdata[0]);
        run_txn(1, 1'b0, 2'b10, 12'h020, 32'h0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
